exp6_condicionador_jogada: RTL

- Input conditioning stage directly upstream of the game control unit.
- Synchronises and debounces the raw player buttons, and accepts only a single clean press-and-release of exactly one button.
- On release, emits a one-cycle `jogada` pulse and holds the one-hot button code in `jogada_valor` for the datapath comparator.
- Rejects presses involving more than one button and reports them on `multipla`.

---
 rtl/exp6_pkg.sv | 19 +
 rtl/exp6_condicionador_jogada_if.sv | 31 +++
 rtl/exp6_debounce_bit.sv | 44 ++++
 rtl/exp6_condicionador_jogada.sv | 97 +++++++++
 4 files changed

// File: rtl/exp6_pkg.sv
// Shared definitions for the play-conditioning stage: FSM state codes and helpers.
// Pure declarations, no logic of its own.
// Imported by the top module of the conditioner.
package exp6_pkg;

  // State codes double as the debug value shown on db_estado.
  typedef enum logic [2:0] {
    ST_OCIOSO      = 3'd0,
    ST_PRESSIONADO = 3'd1,
    ST_EMITE       = 3'd2,
    ST_MULTIPLA    = 3'd3
  } estado_t;

  // True when exactly one bit of the vector is set (narrower vectors are zero-extended).
  function automatic logic um_bit_ativo(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/exp6_condicionador_jogada_if.sv
// Groups the control-unit-facing signals of the play conditioner.
// master = control unit / stimulus side, slave = conditioner.
// No flow control: levels and a one-cycle strobe only.
interface exp6_condicionador_jogada_if #(
  parameter int N_BOTOES = 4
);
  logic                habilita;
  logic [N_BOTOES-1:0] botoes;
  logic                jogada;
  logic [N_BOTOES-1:0] jogada_valor;
  logic                multipla;
  logic [2:0]          db_estado;

  modport master (
    output habilita,
    output botoes,
    input  jogada,
    input  jogada_valor,
    input  multipla,
    input  db_estado
  );

  modport slave (
    input  habilita,
    input  botoes,
    output jogada,
    output jogada_valor,
    output multipla,
    output db_estado
  );
endinterface

// File: rtl/exp6_debounce_bit.sv
// One button: 2-FF synchroniser followed by a stable-level debounce filter.
// Latency: 2 cycles of synchronisation plus DEBOUNCE_CICLOS cycles of stability.
// No backpressure; glitches shorter than DEBOUNCE_CICLOS never reach deb.
module exp6_debounce_bit #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic deb
);
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS - 1);

  logic          sinc_a;
  logic          sinc;
  logic [CW-1:0] cont;

  // Two-stage synchroniser for the asynchronous button level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc_a <= 1'b0;
      sinc   <= 1'b0;
    end else begin
      sinc_a <= botao;
      sinc   <= sinc_a;
    end
  end

  // Count consecutive cycles of disagreement; adopt the new level only after a full run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont <= '0;
      deb  <= 1'b0;
    end else if (sinc == deb) begin
      cont <= '0;
    end else if (cont == LIMITE) begin
      deb  <= sinc;
      cont <= '0;
    end else begin
      cont <= cont + CW'(1);
    end
  end
endmodule

// File: rtl/exp6_condicionador_jogada.sv
// Conditions raw player buttons into single clean plays for the game control unit.
// Latency: debounced release to jogada pulse is 2 cycles (PRESSIONADO->EMITE, then EMITE registers it).
// No backpressure; habilita gates acceptance, multi-button presses are rejected via multipla.
module exp6_condicionador_jogada
  import exp6_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input logic                        clock,
  input logic                        reset,
  exp6_condicionador_jogada_if.slave jogo
);
  logic [N_BOTOES-1:0] deb;
  logic [N_BOTOES-1:0] cand;
  logic [N_BOTOES-1:0] cand_prox;
  logic [N_BOTOES-1:0] valor_r;
  logic [N_BOTOES-1:0] valor_prox;
  logic                jogada_r;
  logic                jogada_prox;
  estado_t             estado;
  estado_t             prox;

  // One synchroniser/debouncer per button.
  for (genvar i = 0; i < N_BOTOES; i++) begin : g_deb
    exp6_debounce_bit #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_deb (
      .clock(clock),
      .reset(reset),
      .botao(jogo.botoes[i]),
      .deb  (deb[i])
    );
  end

  // State, captured candidate and registered outputs; reset drops any pending play.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= ST_OCIOSO;
      cand     <= '0;
      valor_r  <= '0;
      jogada_r <= 1'b0;
    end else begin
      estado   <= prox;
      cand     <= cand_prox;
      valor_r  <= valor_prox;
      jogada_r <= jogada_prox;
    end
  end

  // Next-state and output decisions from the debounced buttons and habilita.
  always_comb begin
    prox        = estado;
    cand_prox   = cand;
    valor_prox  = valor_r;
    jogada_prox = 1'b0;
    case (estado)
      ST_OCIOSO: begin
        // A button already held when habilita rises is accepted here on purpose.
        if (jogo.habilita) begin
          if (um_bit_ativo(32'(deb))) begin
            cand_prox = deb;
            prox      = ST_PRESSIONADO;
          end else if (deb != '0) begin
            prox = ST_MULTIPLA;
          end
        end
      end
      ST_PRESSIONADO: begin
        if (deb == '0) begin
          prox = ST_EMITE;
        end else if ((deb & ~cand) != '0) begin
          prox = ST_MULTIPLA;
        end
      end
      ST_EMITE: begin
        // habilita dropped during the press means the play is silently discarded.
        if (jogo.habilita) begin
          jogada_prox = 1'b1;
          valor_prox  = cand;
        end
        prox = ST_OCIOSO;
      end
      ST_MULTIPLA: begin
        if (deb == '0) begin
          prox = ST_OCIOSO;
        end
      end
      default: prox = ST_OCIOSO;
    endcase
  end

  assign jogo.jogada       = jogada_r;
  assign jogo.jogada_valor = valor_r;
  assign jogo.multipla     = (estado == ST_MULTIPLA);
  assign jogo.db_estado    = estado;
endmodule
